// File: rtl/h_calc_pkg.sv
// Shared definitions for the H load/compute controller family: FSM state
// encodings, default sizing and the address-width helper.
package h_calc_pkg;

  // Default sizing
  localparam int N_DEF   = 32;
  localparam int DIM_DEF = 4;
  localparam int QW_DEF  = 4;

  // Load FSM encodings
  localparam logic [0:0] L_IDLE = 1'b0;
  localparam logic [0:0] L_LOAD = 1'b1;

  // Calc FSM encodings
  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_RUN  = 1'b1;

  // Row/column address width for a DIM x DIM matrix (never narrower than 1 bit)
  function automatic int addr_w(input int dim);
    return (dim <= 2) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/h_bank_ram.sv
// One DIM x DIM complex H bank: a single synchronous write port and an
// asynchronous (combinational) read port addressed by row/column.
module h_bank_ram
  import h_calc_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DIM = DIM_DEF,
  parameter int AW  = addr_w(DIM)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       wr_row_i,
  input  logic [AW-1:0]       wr_col_i,
  input  logic signed [N-1:0] wr_r_i,
  input  logic signed [N-1:0] wr_i_i,
  input  logic [AW-1:0]       rd_row_i,
  input  logic [AW-1:0]       rd_col_i,
  output logic signed [N-1:0] rd_r_o,
  output logic signed [N-1:0] rd_i_o
);

  logic signed [N-1:0] mem_r_q [DIM][DIM];
  logic signed [N-1:0] mem_i_q [DIM][DIM];

  // Sample write: store one complex element at (row, col)
  // NOTE: the storage array has no reset; its contents are only meaningful
  // after a full load, which the controller's full flags guarantee.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_r_q[wr_row_i][wr_col_i] <= wr_r_i;
      mem_i_q[wr_row_i][wr_col_i] <= wr_i_i;
    end
  end

  assign rd_r_o = mem_r_q[rd_row_i][rd_col_i];
  assign rd_i_o = mem_i_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/h_buf_pingpong_ctrl.sv
// Ping-pong H buffer controller: two DIM x DIM complex banks so the next H
// matrix streams in while the Hq engine reads the current one. A load FSM
// fills bank wr_sel, a calc FSM hands bank rd_sel to the engine; per-bank
// full flags order the two and keep them off each other's bank.
// Build option: H_LOAD_COLMAJOR_EN switches the load address order to
// column-major (row advances first). Engine read addressing is unchanged.
module h_buf_pingpong_ctrl
  import h_calc_pkg::*;
#(
  parameter  int N   = N_DEF,
  parameter  int DIM = DIM_DEF,
  parameter  int QW  = QW_DEF,
  localparam int AW  = addr_w(DIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_new_q,
  output logic                start_ready,
  input  logic [QW-1:0]       q_index,
  input  logic                h_in_valid,
  output logic                h_in_ready,
  input  logic signed [N-1:0] h_in_r,
  input  logic signed [N-1:0] h_in_i,
  output logic                eng_start,
  output logic [QW-1:0]       eng_q_index,
  input  logic [AW-1:0]       eng_rd_row,
  input  logic [AW-1:0]       eng_rd_col,
  output logic signed [N-1:0] eng_rd_r,
  output logic signed [N-1:0] eng_rd_i,
  input  logic                eng_done,
  output logic                q_calc_done,
  output logic                busy,
  output logic                err_orphan
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DIM - 1);

  logic [0:0]            l_state_q, l_state_d;
  logic [0:0]            c_state_q, c_state_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [1:0]            full_q, full_d;
  logic [AW-1:0]         row_q, row_d;
  logic [AW-1:0]         col_q, col_d;
  logic [1:0][QW-1:0]    qreg_q, qreg_d;
  logic                  eng_start_q, eng_start_d;
  logic                  calc_done_q, calc_done_d;
  logic                  err_orphan_q, err_orphan_d;
  logic                  ready_en_q;

  logic                  accept;
  logic                  beat;
  logic                  last_beat;
  logic                  calc_free;
  logic signed [N-1:0]   bank_rd_r [2];
  logic signed [N-1:0]   bank_rd_i [2];

  // ready_en_q holds start_ready low through reset and releases it one
  // cycle after reset deasserts, so every output reads 0 while in reset.
  assign start_ready = ready_en_q && (l_state_q == L_IDLE) && !full_q[wr_sel_q];
  assign h_in_ready  = (l_state_q == L_LOAD);
  assign accept      = start_new_q && start_ready;
  assign beat        = h_in_valid && h_in_ready;
  assign last_beat   = beat && (row_q == LAST_IDX) && (col_q == LAST_IDX);

  // Load FSM: capture q on accepted start, then walk the bank address per beat
  // NOTE: every signal assigned here gets a default first so no latch forms.
  always_comb begin
    l_state_d = l_state_q;
    wr_sel_d  = wr_sel_q;
    row_d     = row_q;
    col_d     = col_q;
    qreg_d    = qreg_q;
    unique case (l_state_q)
      L_IDLE: begin
        if (accept) begin
          l_state_d        = L_LOAD;
          row_d            = '0;
          col_d            = '0;
          qreg_d[wr_sel_q] = q_index;
        end
      end
      L_LOAD: begin
        if (last_beat) begin
          l_state_d = L_IDLE;
          wr_sel_d  = ~wr_sel_q;
          row_d     = '0;
          col_d     = '0;
        end else if (beat) begin
`ifdef H_LOAD_COLMAJOR_EN
          if (row_q == LAST_IDX) begin
            row_d = '0;
            col_d = col_q + AW'(1);
          end else begin
            row_d = row_q + AW'(1);
          end
`else
          if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + AW'(1);
          end else begin
            col_d = col_q + AW'(1);
          end
`endif
        end
      end
      default: l_state_d = L_IDLE;
    endcase
  end

  // Calc FSM: start the engine on a full bank, release it on eng_done
  always_comb begin
    c_state_d   = c_state_q;
    rd_sel_d    = rd_sel_q;
    eng_start_d = 1'b0;
    calc_done_d = 1'b0;
    calc_free   = 1'b0;
    unique case (c_state_q)
      C_IDLE: begin
        if (full_q[rd_sel_q]) begin
          eng_start_d = 1'b1;
          c_state_d   = C_RUN;
        end
      end
      C_RUN: begin
        if (eng_done) begin
          calc_free   = 1'b1;
          calc_done_d = 1'b1;
          rd_sel_d    = ~rd_sel_q;
          c_state_d   = C_IDLE;
        end
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  // Full flags: a free and a load-complete on opposite banks both apply
  always_comb begin
    full_d = full_q;
    if (calc_free) full_d[rd_sel_q] = 1'b0;
    if (last_beat) full_d[wr_sel_q] = 1'b1;
  end

  // Sticky error: sample offered while the loader is not accepting
  assign err_orphan_d = err_orphan_q || (h_in_valid && !h_in_ready);

  // State registers with synchronous active-high reset
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_state_q    <= L_IDLE;
      c_state_q    <= C_IDLE;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      full_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      qreg_q       <= '0;
      eng_start_q  <= 1'b0;
      calc_done_q  <= 1'b0;
      err_orphan_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      l_state_q    <= l_state_d;
      c_state_q    <= c_state_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      full_q       <= full_d;
      row_q        <= row_d;
      col_q        <= col_d;
      qreg_q       <= qreg_d;
      eng_start_q  <= eng_start_d;
      calc_done_q  <= calc_done_d;
      err_orphan_q <= err_orphan_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Two banks: writes steered by wr_sel, reads muxed by rd_sel
  for (genvar b = 0; b < 2; b++) begin : g_bank
    h_bank_ram #(
      .N   (N),
      .DIM (DIM),
      .AW  (AW)
    ) u_bank (
      .clk      (clk),
      .we_i     (beat && (wr_sel_q == 1'(b))),
      .wr_row_i (row_q),
      .wr_col_i (col_q),
      .wr_r_i   (h_in_r),
      .wr_i_i   (h_in_i),
      .rd_row_i (eng_rd_row),
      .rd_col_i (eng_rd_col),
      .rd_r_o   (bank_rd_r[b]),
      .rd_i_o   (bank_rd_i[b])
    );
  end

  assign eng_rd_r    = bank_rd_r[rd_sel_q];
  assign eng_rd_i    = bank_rd_i[rd_sel_q];
  assign eng_start   = eng_start_q;
  assign eng_q_index = qreg_q[rd_sel_q];
  assign q_calc_done = calc_done_q;
  assign err_orphan  = err_orphan_q;
  assign busy        = (|full_q) || (l_state_q != L_IDLE) || (c_state_q != C_IDLE);

endmodule

// File: tb/tb_h_buf_pingpong_ctrl.sv
// Bench for h_buf_pingpong_ctrl. A DIM=4 instance is driven through the
// directed scenarios with a scoreboard of expected eng_start / q_calc_done
// events (kind, q index, cycle); a DIM=8 instance checks the load address
// order, whose expected values follow H_LOAD_COLMAJOR_EN.
module tb_h_buf_pingpong_ctrl;

  localparam int N  = 32;
  localparam int QW = 4;
  localparam int K_START = 0;
  localparam int K_DONE  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DIM=4 instance
  logic                start_new_q = 0, start_ready;
  logic [QW-1:0]       q_index = '0;
  logic                h_in_valid = 0, h_in_ready;
  logic signed [N-1:0] h_in_r = '0, h_in_i = '0;
  logic                eng_start;
  logic [QW-1:0]       eng_q_index;
  logic [1:0]          eng_rd_row = '0, eng_rd_col = '0;
  logic signed [N-1:0] eng_rd_r, eng_rd_i;
  logic                eng_done = 0, q_calc_done, busy, err_orphan;

  h_buf_pingpong_ctrl #(.N(N), .DIM(4), .QW(QW)) u_dut (
    .clk(clk), .rst(rst),
    .start_new_q(start_new_q), .start_ready(start_ready), .q_index(q_index),
    .h_in_valid(h_in_valid), .h_in_ready(h_in_ready), .h_in_r(h_in_r), .h_in_i(h_in_i),
    .eng_start(eng_start), .eng_q_index(eng_q_index),
    .eng_rd_row(eng_rd_row), .eng_rd_col(eng_rd_col),
    .eng_rd_r(eng_rd_r), .eng_rd_i(eng_rd_i), .eng_done(eng_done),
    .q_calc_done(q_calc_done), .busy(busy), .err_orphan(err_orphan)
  );

  // DIM=8 instance
  logic                s8_start = 0, s8_start_ready;
  logic [QW-1:0]       s8_q = '0;
  logic                s8_valid = 0, s8_ready;
  logic signed [N-1:0] s8_r = '0, s8_i = '0;
  logic                s8_eng_start;
  logic [QW-1:0]       s8_eng_q;
  logic [2:0]          s8_row = '0, s8_col = '0;
  logic signed [N-1:0] s8_rd_r, s8_rd_i;
  logic                s8_done = 0, s8_calc_done, s8_busy, s8_err;

  h_buf_pingpong_ctrl #(.N(N), .DIM(8), .QW(QW)) u_dut8 (
    .clk(clk), .rst(rst),
    .start_new_q(s8_start), .start_ready(s8_start_ready), .q_index(s8_q),
    .h_in_valid(s8_valid), .h_in_ready(s8_ready), .h_in_r(s8_r), .h_in_i(s8_i),
    .eng_start(s8_eng_start), .eng_q_index(s8_eng_q),
    .eng_rd_row(s8_row), .eng_rd_col(s8_col),
    .eng_rd_r(s8_rd_r), .eng_rd_i(s8_rd_i), .eng_done(s8_done),
    .q_calc_done(s8_calc_done), .busy(s8_busy), .err_orphan(s8_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int kind;
    int q;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int q, input int c);
    exp_t e;
    e.kind = kind;
    e.q    = q;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic do_start(input int q);
    check("start_ready_before_start", start_ready, 1);
    start_new_q = 1;
    q_index     = QW'(q);
    tick();
    start_new_q = 0;
  endtask

  // Drive beats base+k / -(base+k); optionally raise eng_done with the last one
  task automatic load(input int base, input int beats, input bit done_on_last, output int last);
    last = 0;
    for (int k = 0; k < beats; k++) begin
      h_in_valid = 1;
      h_in_r     = base + k;
      h_in_i     = -(base + k);
      if (done_on_last && k == beats - 1) eng_done = 1;
      last = cyc;
      tick();
    end
    h_in_valid = 0;
    eng_done   = 0;
  endtask

  task automatic pulse_done(input int q_next, input bit expect_start);
    eng_done = 1;
    push(K_DONE, 0, cyc + 1);
    if (expect_start) push(K_START, q_next, cyc + 2);
    tick();
    eng_done = 0;
  endtask

  // Monitor: every engine-side event must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) begin
        check("sb_has_entry_for_eng_start", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("event_kind_start", mon_e.kind, K_START);
          check("eng_q_index_at_start", eng_q_index, mon_e.q);
          check("eng_start_cycle", cyc, mon_e.cyc);
        end
      end
      if (q_calc_done) begin
        check("sb_has_entry_for_done", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("event_kind_done", mon_e.kind, K_DONE);
          check("q_calc_done_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  last, la;
    bit  seen;

    // Reset values
    rst = 1;
    repeat (3) tick();
    check("rst_start_ready", start_ready, 0);
    check("rst_h_in_ready", h_in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_q_calc_done", q_calc_done, 0);
    check("rst_err_orphan", err_orphan, 0);
    check("rst_eng_q_index", eng_q_index, 0);
    rst = 0;
    tick();
    check("start_ready_after_rst", start_ready, 1);

    // 1: single matrix, q=5, r=k, i=-k
    do_start(5);
    load(0, 16, 0, last);
    push(K_START, 5, last + 2);
    tick();
    eng_rd_row = 2'd2;
    eng_rd_col = 2'd3;
    #1;
    check("t1_rd_r_2_3", eng_rd_r, 11);
    check("t1_rd_i_2_3", eng_rd_i, -11);
    check("t1_eng_q_index", eng_q_index, 5);
    check("t1_busy_running", busy, 1);
    tick();
    pulse_done(0, 0);
    check("t1_busy_after_done", busy, 0);
    check("t1_start_ready_after_done", start_ready, 1);

    // 2: back-to-back q=1 then q=2, third start refused
    do_start(1);
    load(100, 16, 0, last);
    push(K_START, 1, last + 2);
    do_start(2);
    load(200, 16, 0, last);
    check("t2_start_ready_both_full", start_ready, 0);
    start_new_q = 1;
    q_index     = 4'd9;
    tick();
    start_new_q = 0;
    check("t2_refused_no_load", h_in_ready, 0);
    check("t2_eng_q_index_first", eng_q_index, 1);
    eng_rd_row = 2'd0;
    eng_rd_col = 2'd0;
    #1;
    check("t2_rd_first_bank", eng_rd_r, 100);
    pulse_done(2, 1);
    tick();
    check("t2_eng_q_index_second", eng_q_index, 2);
    eng_rd_row = 2'd3;
    eng_rd_col = 2'd3;
    #1;
    check("t2_rd_second_bank_r", eng_rd_r, 215);
    check("t2_rd_second_bank_i", eng_rd_i, -215);
    tick();
    pulse_done(0, 0);

    // 3: eng_done for q=3 in the same cycle the q=4 load completes
    do_start(3);
    load(300, 16, 0, la);
    push(K_START, 3, la + 2);
    do_start(4);
    load(400, 16, 1, last);
    push(K_DONE, 0, last + 1);
    push(K_START, 4, last + 2);
    tick();
    tick();
    eng_rd_row = 2'd1;
    eng_rd_col = 2'd1;
    #1;
    check("t3_rd_q4_bank", eng_rd_r, 405);
    check("t3_eng_q_index", eng_q_index, 4);
    pulse_done(0, 0);
    tick();
    check("t3_idle_busy", busy, 0);

    // 4: orphan sample in L_IDLE
    check("t4_err_before", err_orphan, 0);
    h_in_valid = 1;
    tick();
    h_in_valid = 0;
    check("t4_err_set", err_orphan, 1);
    repeat (3) tick();
    check("t4_err_sticky", err_orphan, 1);

    // 5: reset in the middle of a load
    do_start(7);
    load(700, 7, 0, last);
    rst = 1;
    tick();
    tick();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_h_in_ready", h_in_ready, 0);
    check("t5_rst_err_cleared", err_orphan, 0);
    check("t5_rst_start_ready", start_ready, 0);
    rst = 0;
    tick();
    check("t5_start_ready_after_rst", start_ready, 1);
    do_start(8);
    load(800, 16, 0, last);
    push(K_START, 8, last + 2);
    tick();
    tick();
    pulse_done(0, 0);
    repeat (4) tick();
    check("sb_drained", sb.size(), 0);

    // 6: DIM=8 load order, beat k carries k
    check("t6_start_ready", s8_start_ready, 1);
    s8_start = 1;
    s8_q     = 4'd6;
    tick();
    s8_start = 0;
    for (int k = 0; k < 64; k++) begin
      s8_valid = 1;
      s8_r     = k;
      s8_i     = -k;
      tick();
    end
    s8_valid = 0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (s8_eng_start) seen = 1;
    end
    check("t6_eng_start_seen", seen, 1);
    check("t6_eng_q_index", s8_eng_q, 6);
    s8_row = 3'd1;
    s8_col = 3'd0;
    #1;
`ifdef H_LOAD_COLMAJOR_EN
    check("t6_rd_1_0", s8_rd_r, 1);
`else
    check("t6_rd_1_0", s8_rd_r, 8);
`endif
    s8_row = 3'd0;
    s8_col = 3'd1;
    #1;
`ifdef H_LOAD_COLMAJOR_EN
    check("t6_rd_0_1", s8_rd_r, 8);
`else
    check("t6_rd_0_1", s8_rd_r, 1);
`endif
    check("t6_rd_0_1_imag", s8_rd_i, -s8_rd_r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
